// File: rtl/l1_ahb_mtx_in_stg_if.sv
// Master-side AHB signals of one L1 bus-matrix slave port.
// The master modport is used by whatever drives the port (master or bench).
// The slave modport is used by the input stage.
interface l1_ahb_mtx_in_stg_if;
  logic        HSELS;
  logic [31:0] HADDRS;
  logic [1:0]  HTRANSS;
  logic        HWRITES;
  logic [2:0]  HSIZES;
  logic [2:0]  HBURSTS;
  logic [3:0]  HPROTS;
  logic        HREADYS;
  logic        HREADYOUTS;
  logic [1:0]  HRESPS;

  modport master (
    output HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS, HREADYS,
    input  HREADYOUTS, HRESPS
  );

  modport slave (
    input  HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS, HREADYS,
    output HREADYOUTS, HRESPS
  );
endinterface

// File: rtl/l1_ahb_mtx_in_stg.sv
// L1 AHB bus-matrix input stage for one slave port.
// It passes address-phase controls straight to the decoder. When the target
// output stage is busy, it parks the transfer in a holding register and
// stalls the master until the output stage accepts it. Data-phase ready and
// response from the decoder are routed back to the master.
module l1_ahb_mtx_in_stg (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  l1_ahb_mtx_in_stg_if.slave        ahb,
  output logic                      sel_in,
  output logic [31:0]               addr_in,
  output logic [1:0]                trans_in,
  output logic                      write_in,
  output logic [2:0]                size_in,
  output logic [2:0]                burst_in,
  output logic [3:0]                prot_in,
  output logic                      ready_in,
  output logic                      held_tran,
  input  logic                      active_dec,
  input  logic                      readyout_dec,
  input  logic [1:0]                resp_dec
);

  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;
  localparam logic [2:0] BURST_INCR   = 3'b001;

  logic        pend_r;
  logic        dphase_r;
  logic [31:0] hold_addr_r;
  logic [1:0]  hold_trans_r;
  logic        hold_write_r;
  logic [2:0]  hold_size_r;
  logic [2:0]  hold_burst_r;
  logic [3:0]  hold_prot_r;

  logic new_tran_s;
  logic capture_s;
  logic release_s;
  logic accept_s;

  // Transfer qualification: capture, release and downstream acceptance.
  always_comb begin
    new_tran_s = ahb.HSELS & ahb.HTRANSS[1] & ahb.HREADYS;
    capture_s  = new_tran_s & ~active_dec & ~pend_r;
    release_s  = pend_r & active_dec;
    accept_s   = release_s | (~pend_r & new_tran_s & active_dec);
  end

  // Pending flag and holding register; release always wins over a new capture
  // because capture is only possible while nothing is pending.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      pend_r       <= 1'b0;
      hold_addr_r  <= 32'h0000_0000;
      hold_trans_r <= 2'b00;
      hold_write_r <= 1'b0;
      hold_size_r  <= 3'b000;
      hold_burst_r <= 3'b000;
      hold_prot_r  <= 4'b0000;
    end else if (capture_s) begin
      pend_r       <= 1'b1;
      hold_addr_r  <= ahb.HADDRS;
      hold_trans_r <= ahb.HTRANSS;
      hold_write_r <= ahb.HWRITES;
      hold_size_r  <= ahb.HSIZES;
      hold_burst_r <= ahb.HBURSTS;
      hold_prot_r  <= ahb.HPROTS;
    end else if (release_s) begin
      pend_r       <= 1'b0;
    end else begin
      pend_r       <= pend_r;
    end
  end

  // Outstanding data phase: set on acceptance, cleared when it completes.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      dphase_r <= 1'b0;
    end else if (accept_s) begin
      dphase_r <= 1'b1;
    end else if (ready_in & readyout_dec) begin
      dphase_r <= 1'b0;
    end else begin
      dphase_r <= dphase_r;
    end
  end

  // Decoder-side controls: live master signals, or the held transfer.
  // A held SEQ beat is re-issued as a standalone NONSEQ INCR, since the
  // burst context is lost while the master was stalled.
  always_comb begin
    sel_in    = ahb.HSELS;
    addr_in   = ahb.HADDRS;
    trans_in  = ahb.HTRANSS;
    write_in  = ahb.HWRITES;
    size_in   = ahb.HSIZES;
    burst_in  = ahb.HBURSTS;
    prot_in   = ahb.HPROTS;
    ready_in  = ahb.HREADYS;
    held_tran = 1'b0;
    if (pend_r) begin
      sel_in    = 1'b1;
      addr_in   = hold_addr_r;
      write_in  = hold_write_r;
      size_in   = hold_size_r;
      prot_in   = hold_prot_r;
      ready_in  = 1'b1;
      held_tran = 1'b1;
      if (hold_trans_r == TRANS_SEQ) begin
        trans_in = TRANS_NONSEQ;
        burst_in = BURST_INCR;
      end else begin
        trans_in = hold_trans_r;
        burst_in = hold_burst_r;
      end
    end else begin
      held_tran = 1'b0;
    end
  end

  // Master-side ready and response.
  always_comb begin
    ahb.HREADYOUTS = 1'b1;
    ahb.HRESPS     = 2'b00;
    if (pend_r) begin
      ahb.HREADYOUTS = 1'b0;
    end else if (dphase_r) begin
      ahb.HREADYOUTS = readyout_dec;
      ahb.HRESPS     = resp_dec;
    end else begin
      ahb.HREADYOUTS = 1'b1;
    end
  end

endmodule

// File: tb/tb_l1_ahb_mtx_in_stg.sv
// Directed scoreboard bench for l1_ahb_mtx_in_stg. Inputs change on the
// falling edge. Expectations are queued with the stimulus and checked 2 ns
// later, before the rising edge.
module tb_l1_ahb_mtx_in_stg;

  logic        HCLK;
  logic        HRESETn;
  logic        sel_in;
  logic [31:0] addr_in;
  logic [1:0]  trans_in;
  logic        write_in;
  logic [2:0]  size_in;
  logic [2:0]  burst_in;
  logic [3:0]  prot_in;
  logic        ready_in;
  logic        held_tran;
  logic        active_dec;
  logic        readyout_dec;
  logic [1:0]  resp_dec;

  l1_ahb_mtx_in_stg_if ahb ();

  l1_ahb_mtx_in_stg dut (
    .HCLK         (HCLK),
    .HRESETn      (HRESETn),
    .ahb          (ahb),
    .sel_in       (sel_in),
    .addr_in      (addr_in),
    .trans_in     (trans_in),
    .write_in     (write_in),
    .size_in      (size_in),
    .burst_in     (burst_in),
    .prot_in      (prot_in),
    .ready_in     (ready_in),
    .held_tran    (held_tran),
    .active_dec   (active_dec),
    .readyout_dec (readyout_dec),
    .resp_dec     (resp_dec)
  );

  localparam int S_RDYOUT = 0;
  localparam int S_RESP   = 1;
  localparam int S_SEL    = 2;
  localparam int S_ADDR   = 3;
  localparam int S_TRANS  = 4;
  localparam int S_BURST  = 5;
  localparam int S_HELD   = 6;
  localparam int S_RDYIN  = 7;
  localparam int S_WRITE  = 8;

  typedef struct {
    string       tag;
    int          sig;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk;
  int   n_fail;

  // Clock generation.
  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  // Single comparison point: counts and reports mismatches.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] observe(input int sig);
    case (sig)
      S_RDYOUT: observe = {31'd0, ahb.HREADYOUTS};
      S_RESP:   observe = {30'd0, ahb.HRESPS};
      S_SEL:    observe = {31'd0, sel_in};
      S_ADDR:   observe = addr_in;
      S_TRANS:  observe = {30'd0, trans_in};
      S_BURST:  observe = {29'd0, burst_in};
      S_HELD:   observe = {31'd0, held_tran};
      S_RDYIN:  observe = {31'd0, ready_in};
      S_WRITE:  observe = {31'd0, write_in};
      default:  observe = 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic expect_v(input string tag, input int sig, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.sig = sig;
    e.val = val;
    sb_q.push_back(e);
  endtask

  // Let outputs settle, drain the scoreboard, advance to the next falling edge.
  task automatic tick();
    exp_t e;
    #2;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk(e.tag, observe(e.sig), e.val);
    end
    @(negedge HCLK);
  endtask

  task automatic mst(input logic sel, input logic [1:0] tr, input logic [31:0] a,
                     input logic wr, input logic [2:0] bu, input logic rdy);
    ahb.HSELS   = sel;
    ahb.HTRANSS = tr;
    ahb.HADDRS  = a;
    ahb.HWRITES = wr;
    ahb.HSIZES  = 3'b010;
    ahb.HBURSTS = bu;
    ahb.HPROTS  = 4'b0011;
    ahb.HREADYS = rdy;
  endtask

  task automatic dec(input logic act, input logic rdo, input logic [1:0] rsp);
    active_dec   = act;
    readyout_dec = rdo;
    resp_dec     = rsp;
  endtask

  task automatic idle(input logic rdy);
    mst(1'b0, 2'b00, 32'h0000_0000, 1'b0, 3'b000, rdy);
  endtask

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    HRESETn = 1'b0;
    idle(1'b1);
    dec(1'b0, 1'b1, 2'b00);
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    HRESETn = 1'b1;

    // Reset state
    expect_v("rst_rdyout", S_RDYOUT, 32'd1);
    expect_v("rst_resp",   S_RESP,   32'd0);
    expect_v("rst_held",   S_HELD,   32'd0);
    expect_v("rst_sel",    S_SEL,    32'd0);
    expect_v("rst_rdyin",  S_RDYIN,  32'd1);
    tick();

    // Pass-through write, then data phase with readyout 0,0,1
    mst(1'b1, 2'b10, 32'h0000_1000, 1'b1, 3'b000, 1'b1);
    dec(1'b1, 1'b1, 2'b00);
    expect_v("pt_sel",    S_SEL,    32'd1);
    expect_v("pt_addr",   S_ADDR,   32'h0000_1000);
    expect_v("pt_trans",  S_TRANS,  32'd2);
    expect_v("pt_write",  S_WRITE,  32'd1);
    expect_v("pt_held",   S_HELD,   32'd0);
    expect_v("pt_rdyout", S_RDYOUT, 32'd1);
    tick();
    for (int i = 0; i < 3; i++) begin
      idle(i == 2);
      dec(1'b0, (i == 2), 2'b00);
      expect_v("pt_dp_rdyout", S_RDYOUT, (i == 2) ? 32'd1 : 32'd0);
      tick();
    end
    idle(1'b1);
    dec(1'b0, 1'b0, 2'b00);
    expect_v("pt_done_rdyout", S_RDYOUT, 32'd1);
    tick();

    // Hold: capture with active_dec=0, three stalled cycles, then release
    mst(1'b1, 2'b10, 32'h0000_0400, 1'b0, 3'b000, 1'b1);
    dec(1'b0, 1'b1, 2'b00);
    expect_v("hold_cap_rdyout", S_RDYOUT, 32'd1);
    expect_v("hold_cap_held",   S_HELD,   32'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      mst(1'b1, 2'b10, 32'h0000_0400, 1'b0, 3'b000, 1'b0);
      dec((i == 3), 1'b1, 2'b01);
      expect_v("hold_rdyout", S_RDYOUT, 32'd0);
      expect_v("hold_held",   S_HELD,   32'd1);
      expect_v("hold_addr",   S_ADDR,   32'h0000_0400);
      expect_v("hold_sel",    S_SEL,    32'd1);
      expect_v("hold_rdyin",  S_RDYIN,  32'd1);
      expect_v("hold_resp",   S_RESP,   32'd0);
      tick();
    end
    idle(1'b0);
    dec(1'b0, 1'b0, 2'b00);
    expect_v("hold_dp_rdyout", S_RDYOUT, 32'd0);
    expect_v("hold_dp_held",   S_HELD,   32'd0);
    expect_v("hold_dp_sel",    S_SEL,    32'd0);
    tick();
    idle(1'b1);
    dec(1'b0, 1'b1, 2'b00);
    expect_v("hold_end_rdyout", S_RDYOUT, 32'd1);
    tick();

    // SEQ beat held -> presented as NONSEQ INCR
    mst(1'b1, 2'b11, 32'h0000_2004, 1'b0, 3'b011, 1'b1);
    dec(1'b0, 1'b1, 2'b00);
    expect_v("seq_live_trans", S_TRANS, 32'd3);
    expect_v("seq_live_burst", S_BURST, 32'd3);
    tick();
    for (int i = 0; i < 2; i++) begin
      mst(1'b1, 2'b11, 32'h0000_2004, 1'b0, 3'b011, 1'b0);
      dec((i == 1), 1'b1, 2'b00);
      expect_v("seq_held_trans", S_TRANS, 32'd2);
      expect_v("seq_held_burst", S_BURST, 32'd1);
      expect_v("seq_held_addr",  S_ADDR,  32'h0000_2004);
      tick();
    end
    idle(1'b1);
    dec(1'b0, 1'b1, 2'b00);
    expect_v("seq_dp_rdyout", S_RDYOUT, 32'd1);
    tick();

    // Two-cycle error response, then master goes IDLE
    mst(1'b1, 2'b10, 32'h0000_3000, 1'b1, 3'b000, 1'b1);
    dec(1'b1, 1'b1, 2'b00);
    tick();
    idle(1'b0);
    dec(1'b0, 1'b0, 2'b01);
    expect_v("err1_resp",   S_RESP,   32'd1);
    expect_v("err1_rdyout", S_RDYOUT, 32'd0);
    tick();
    mst(1'b1, 2'b00, 32'h0000_3004, 1'b0, 3'b000, 1'b1);
    dec(1'b0, 1'b1, 2'b01);
    expect_v("err2_resp",   S_RESP,   32'd1);
    expect_v("err2_rdyout", S_RDYOUT, 32'd1);
    tick();
    idle(1'b1);
    dec(1'b0, 1'b0, 2'b01);
    expect_v("err_idle_held",   S_HELD,   32'd0);
    expect_v("err_idle_rdyout", S_RDYOUT, 32'd1);
    expect_v("err_idle_resp",   S_RESP,   32'd0);
    tick();

    // Capture while the previous data phase completes
    mst(1'b1, 2'b10, 32'h0000_4000, 1'b0, 3'b000, 1'b1);
    dec(1'b1, 1'b1, 2'b00);
    tick();
    mst(1'b1, 2'b10, 32'h0000_5000, 1'b0, 3'b000, 1'b1);
    dec(1'b0, 1'b1, 2'b00);
    expect_v("ovl_rdyout", S_RDYOUT, 32'd1);
    tick();
    mst(1'b1, 2'b10, 32'h0000_5000, 1'b0, 3'b000, 1'b0);
    dec(1'b1, 1'b1, 2'b01);
    expect_v("ovl_held_rdyout", S_RDYOUT, 32'd0);
    expect_v("ovl_held_resp",   S_RESP,   32'd0);
    expect_v("ovl_held_addr",   S_ADDR,   32'h0000_5000);
    tick();
    idle(1'b0);
    dec(1'b0, 1'b0, 2'b00);
    expect_v("ovl_dp_rdyout", S_RDYOUT, 32'd0);
    tick();
    idle(1'b1);
    dec(1'b0, 1'b1, 2'b00);
    expect_v("ovl_end_rdyout", S_RDYOUT, 32'd1);
    tick();

    // Back-to-back pass-through, data phase stays outstanding
    mst(1'b1, 2'b10, 32'h0000_6000, 1'b1, 3'b000, 1'b1);
    dec(1'b1, 1'b1, 2'b00);
    expect_v("b2b1_rdyout", S_RDYOUT, 32'd1);
    tick();
    mst(1'b1, 2'b10, 32'h0000_6004, 1'b1, 3'b000, 1'b1);
    dec(1'b1, 1'b1, 2'b01);
    expect_v("b2b2_rdyout", S_RDYOUT, 32'd1);
    expect_v("b2b2_addr",   S_ADDR,   32'h0000_6004);
    expect_v("b2b2_resp",   S_RESP,   32'd1);
    tick();
    idle(1'b1);
    dec(1'b0, 1'b1, 2'b01);
    expect_v("b2b3_resp", S_RESP, 32'd1);
    tick();
    idle(1'b1);
    dec(1'b0, 1'b1, 2'b01);
    expect_v("b2b4_resp", S_RESP, 32'd0);
    tick();

    // Reset in the middle of a hold discards the held transfer
    mst(1'b1, 2'b10, 32'h0000_7000, 1'b0, 3'b000, 1'b1);
    dec(1'b0, 1'b1, 2'b00);
    tick();
    mst(1'b1, 2'b10, 32'h0000_7000, 1'b0, 3'b000, 1'b0);
    expect_v("rh_held", S_HELD, 32'd1);
    tick();
    HRESETn = 1'b0;
    idle(1'b1);
    tick();
    tick();
    HRESETn = 1'b1;
    dec(1'b1, 1'b1, 2'b00);
    expect_v("rh_held0",  S_HELD,   32'd0);
    expect_v("rh_rdyout", S_RDYOUT, 32'd1);
    expect_v("rh_resp",   S_RESP,   32'd0);
    expect_v("rh_sel",    S_SEL,    32'd0);
    tick();
    dec(1'b1, 1'b0, 2'b01);
    expect_v("rh_post_sel",    S_SEL,    32'd0);
    expect_v("rh_post_rdyout", S_RDYOUT, 32'd1);
    expect_v("rh_post_resp",   S_RESP,   32'd0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
